// File: rtl/game_pkg.sv
// Shared game-state encodings and score/frame constants for the game controller and State consumers.
package game_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 10;
    localparam int unsigned FRAME_W = 16;

    typedef enum logic [STATE_W-1:0] {
        MENU      = 3'd0,
        LEVEL1    = 3'd1,
        LEVEL2    = 3'd2,
        LEVEL3    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;
    localparam logic [FRAME_W-1:0] FRAME_MAX = '1;

endpackage

// File: rtl/game_state_fsm_sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The output pulse is one Clk wide and appears three Clk after the input rises.
module sync_edge_det (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/game_state_fsm.sv
// Game state controller: menu, three difficulty levels and game over, with
// frame-based promotion, per-second score and best-score tracking.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int unsigned LEVEL2_FRAMES  = 600,
    parameter int unsigned LEVEL3_FRAMES  = 1800,
    parameter int unsigned GAMEOVER_HOLD  = 120,
    parameter int unsigned FRAMES_PER_SEC = 60
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               VGA_VS,
    input  logic               start_key,
    input  logic               collision,
    output logic [STATE_W-1:0] State,
    output logic               game_reset,
    output logic [SCORE_W-1:0] score_sec,
    output logic [SCORE_W-1:0] best_sec
);

    localparam int unsigned SUB_W  = $clog2(FRAMES_PER_SEC + 1);
    localparam int unsigned HOLD_W = $clog2(GAMEOVER_HOLD + 1);

    localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_DONE = HOLD_W'(GAMEOVER_HOLD);
    localparam logic [FRAME_W-1:0] L2_AT     = FRAME_W'(LEVEL2_FRAMES);
    localparam logic [FRAME_W-1:0] L3_AT     = FRAME_W'(LEVEL3_FRAMES);

    logic frame_tick;
    logic start_edge;

    state_t              state_q,      state_n;
    logic                game_reset_n;
    logic [FRAME_W-1:0]  run_frames_q, run_frames_n;
    logic [SUB_W-1:0]    sub_q,        sub_n;
    logic [HOLD_W-1:0]   hold_q,       hold_n;
    logic [SCORE_W-1:0]  score_n;
    logic [SCORE_W-1:0]  best_n;

    sync_edge_det u_vs_det (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (VGA_VS),
        .rise    (frame_tick)
    );

    sync_edge_det u_start_det (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (start_key),
        .rise    (start_edge)
    );

    assign State = state_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= MENU;
            game_reset   <= 1'b0;
            run_frames_q <= '0;
            sub_q        <= '0;
            hold_q       <= '0;
            score_sec    <= '0;
            best_sec     <= '0;
        end else begin
            state_q      <= state_n;
            game_reset   <= game_reset_n;
            run_frames_q <= run_frames_n;
            sub_q        <= sub_n;
            hold_q       <= hold_n;
            score_sec    <= score_n;
            best_sec     <= best_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        game_reset_n = 1'b0;
        run_frames_n = run_frames_q;
        sub_n        = sub_q;
        hold_n       = hold_q;
        score_n      = score_sec;
        best_n       = best_sec;

        case (state_q)
            MENU: begin
                if (start_edge) begin
                    state_n      = LEVEL1;
                    game_reset_n = 1'b1;
                    run_frames_n = '0;
                    sub_n        = '0;
                    score_n      = '0;
                end
            end

            LEVEL1, LEVEL2, LEVEL3: begin
                // Collision pre-empts both promotion and the frame count for this cycle
                if (collision) begin
                    state_n = GAME_OVER;
                    hold_n  = '0;
                end else begin
                    if (frame_tick) begin
                        if (run_frames_q != FRAME_MAX) begin
                            run_frames_n = run_frames_q + FRAME_W'(1);
                        end
                        if (sub_q == SUB_LAST) begin
                            sub_n = '0;
                            if (score_sec != SCORE_MAX) begin
                                score_n = score_sec + SCORE_W'(1);
                            end
                        end else begin
                            sub_n = sub_q + SUB_W'(1);
                        end
                    end
                    if (state_q == LEVEL1 && run_frames_q >= L2_AT) begin
                        state_n = LEVEL2;
                    end else if (state_q == LEVEL2 && run_frames_q >= L3_AT) begin
                        state_n = LEVEL3;
                    end
                end
            end

            GAME_OVER: begin
                if (score_sec > best_sec) begin
                    best_n = score_sec;
                end
                // Presses before the hold expires are simply dropped
                if (start_edge && hold_q >= HOLD_DONE) begin
                    state_n      = LEVEL1;
                    game_reset_n = 1'b1;
                    run_frames_n = '0;
                    sub_n        = '0;
                    score_n      = '0;
                end else if (frame_tick && hold_q < HOLD_DONE) begin
                    hold_n = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_n = MENU;
            end
        endcase
    end

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm: reset, start, promotion, collision priority,
// game-over hold, best-score retention, score saturation and illegal-state recovery.
module tb_game_state_fsm;
    import game_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       vga_vs;
    logic       start_key;
    logic       collision;
    logic [2:0] state;
    logic       game_reset;
    logic [9:0] score_sec;
    logic [9:0] best_sec;

    logic       vga_vs2;
    logic       start_key2;
    logic       collision2;
    logic [2:0] state2;
    logic       game_reset2;
    logic [9:0] score_sec2;
    logic [9:0] best_sec2;

    int vec  = 0;
    int errs = 0;

    always #5 Clk = ~Clk;

    game_state_fsm #(
        .LEVEL2_FRAMES  (4),
        .LEVEL3_FRAMES  (8),
        .GAMEOVER_HOLD  (3),
        .FRAMES_PER_SEC (2)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .VGA_VS     (vga_vs),
        .start_key  (start_key),
        .collision  (collision),
        .State      (state),
        .game_reset (game_reset),
        .score_sec  (score_sec),
        .best_sec   (best_sec)
    );

    game_state_fsm #(
        .LEVEL2_FRAMES  (4),
        .LEVEL3_FRAMES  (8),
        .GAMEOVER_HOLD  (3),
        .FRAMES_PER_SEC (1)
    ) dut2 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .VGA_VS     (vga_vs2),
        .start_key  (start_key2),
        .collision  (collision2),
        .State      (state2),
        .game_reset (game_reset2),
        .score_sec  (score_sec2),
        .best_sec   (best_sec2)
    );

    // One VS pulse; returns five negedges later, after the tick has been absorbed.
    task automatic tick();
        vga_vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 1) vga_vs = 1'b0;
        end
    endtask

    task automatic tick2();
        vga_vs2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 1) vga_vs2 = 1'b0;
        end
    endtask

    // Start-key press; reports whether game_reset was seen during the window.
    task automatic press(output logic gr_seen);
        gr_seen   = 1'b0;
        start_key = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 1) start_key = 1'b0;
            gr_seen = gr_seen | game_reset;
        end
    endtask

    task automatic test_reset();
        logic g;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        vec++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state: got %0d expected 0", state); end
        vec++; if (game_reset !== 1'b0) begin errs++; $display("FAIL reset_game_reset: got %0b expected 0", game_reset); end
        vec++; if (score_sec !== 10'd0) begin errs++; $display("FAIL reset_score: got %0d expected 0", score_sec); end
        vec++; if (best_sec !== 10'd0) begin errs++; $display("FAIL reset_best: got %0d expected 0", best_sec); end
        Reset_n = 1'b1;
        @(negedge Clk);
        press(g);
        repeat (3) tick();
        vec++; if (score_sec !== 10'd1) begin errs++; $display("FAIL midrun_score: got %0d expected 1", score_sec); end
        Reset_n = 1'b0;
        #1;
        vec++; if (state !== 3'd0) begin errs++; $display("FAIL async_reset_state: got %0d expected 0", state); end
        vec++; if (score_sec !== 10'd0) begin errs++; $display("FAIL async_reset_score: got %0d expected 0", score_sec); end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_start();
        start_key = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        start_key = 1'b0;
        @(negedge Clk);
        vec++; if (state !== 3'd0) begin errs++; $display("FAIL start_latency_state: got %0d expected 0", state); end
        vec++; if (game_reset !== 1'b0) begin errs++; $display("FAIL start_early_pulse: got %0b expected 0", game_reset); end
        @(negedge Clk);
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL start_state: got %0d expected 1", state); end
        vec++; if (game_reset !== 1'b1) begin errs++; $display("FAIL start_pulse: got %0b expected 1", game_reset); end
        vec++; if (score_sec !== 10'd0) begin errs++; $display("FAIL start_score: got %0d expected 0", score_sec); end
        @(negedge Clk);
        vec++; if (game_reset !== 1'b0) begin errs++; $display("FAIL start_pulse_width: got %0b expected 0", game_reset); end
    endtask

    task automatic test_collision_priority();
        repeat (3) tick();
        vec++; if (score_sec !== 10'd1) begin errs++; $display("FAIL coll_pre_score: got %0d expected 1", score_sec); end
        vga_vs = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        vga_vs = 1'b0;
        @(negedge Clk);
        collision = 1'b1;
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL coll_pre_state: got %0d expected 1", state); end
        @(negedge Clk);
        collision = 1'b0;
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL coll_state: got %0d expected 4", state); end
        vec++; if (score_sec !== 10'd1) begin errs++; $display("FAIL coll_score: got %0d expected 1", score_sec); end
        vec++; if (best_sec !== 10'd0) begin errs++; $display("FAIL coll_best_entry: got %0d expected 0", best_sec); end
        @(negedge Clk);
        vec++; if (best_sec !== 10'd1) begin errs++; $display("FAIL coll_best_next: got %0d expected 1", best_sec); end
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL coll_state_hold: got %0d expected 4", state); end
    endtask

    task automatic test_gameover_hold();
        logic g;
        repeat (2) tick();
        press(g);
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL hold_early_state: got %0d expected 4", state); end
        vec++; if (g !== 1'b0) begin errs++; $display("FAIL hold_early_pulse: got %0b expected 0", g); end
        tick();
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL hold_not_queued: got %0d expected 4", state); end
        press(g);
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL hold_exit_state: got %0d expected 1", state); end
        vec++; if (g !== 1'b1) begin errs++; $display("FAIL hold_exit_pulse: got %0b expected 1", g); end
        vec++; if (score_sec !== 10'd0) begin errs++; $display("FAIL hold_exit_score: got %0d expected 0", score_sec); end
        vec++; if (best_sec !== 10'd1) begin errs++; $display("FAIL hold_exit_best: got %0d expected 1", best_sec); end
    endtask

    task automatic test_best_kept();
        logic g;
        collision = 1'b1;
        @(negedge Clk);
        collision = 1'b0;
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL worse_state: got %0d expected 4", state); end
        repeat (2) @(negedge Clk);
        vec++; if (best_sec !== 10'd1) begin errs++; $display("FAIL worse_best: got %0d expected 1", best_sec); end
        vec++; if (score_sec !== 10'd0) begin errs++; $display("FAIL worse_score: got %0d expected 0", score_sec); end
        repeat (3) tick();
        press(g);
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL worse_restart: got %0d expected 1", state); end
    endtask

    task automatic test_promotion();
        logic g;
        press(g);
        vec++; if (g !== 1'b0) begin errs++; $display("FAIL level_start_pulse: got %0b expected 0", g); end
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL level_start_state: got %0d expected 1", state); end
        repeat (3) tick();
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL promo_3ticks: got %0d expected 1", state); end
        tick();
        vec++; if (state !== 3'd2) begin errs++; $display("FAIL promo_l2: got %0d expected 2", state); end
        repeat (4) tick();
        vec++; if (state !== 3'd3) begin errs++; $display("FAIL promo_l3: got %0d expected 3", state); end
        vec++; if (score_sec !== 10'd4) begin errs++; $display("FAIL promo_score8: got %0d expected 4", score_sec); end
        repeat (20) tick();
        vec++; if (state !== 3'd3) begin errs++; $display("FAIL promo_l3_terminal: got %0d expected 3", state); end
        vec++; if (score_sec !== 10'd14) begin errs++; $display("FAIL promo_score28: got %0d expected 14", score_sec); end
        collision = 1'b1;
        @(negedge Clk);
        collision = 1'b0;
        @(negedge Clk);
        vec++; if (state !== 3'd4) begin errs++; $display("FAIL promo_end_state: got %0d expected 4", state); end
        vec++; if (best_sec !== 10'd14) begin errs++; $display("FAIL promo_best: got %0d expected 14", best_sec); end
    endtask

    task automatic test_saturation();
        start_key2 = 1'b1;
        repeat (2) @(negedge Clk);
        start_key2 = 1'b0;
        repeat (3) @(negedge Clk);
        vec++; if (state2 !== 3'd1) begin errs++; $display("FAIL sat_start: got %0d expected 1", state2); end
        repeat (998) tick2();
        vec++; if (score_sec2 !== 10'd998) begin errs++; $display("FAIL sat_998: got %0d expected 998", score_sec2); end
        repeat (7) tick2();
        vec++; if (score_sec2 !== 10'd999) begin errs++; $display("FAIL sat_999: got %0d expected 999", score_sec2); end
        vec++; if (state2 !== 3'd3) begin errs++; $display("FAIL sat_state: got %0d expected 3", state2); end
        force dut2.state_q = state_t'(3'd6);
        #1;
        release dut2.state_q;
        @(negedge Clk);
        vec++; if (state2 !== 3'd0) begin errs++; $display("FAIL illegal_recover: got %0d expected 0", state2); end
        vec++; if (game_reset2 !== 1'b0) begin errs++; $display("FAIL illegal_pulse: got %0b expected 0", game_reset2); end
        vec++; if (best_sec2 !== 10'd0) begin errs++; $display("FAIL illegal_best: got %0d expected 0", best_sec2); end
    endtask

    initial begin
        Reset_n    = 1'b0;
        vga_vs     = 1'b0;
        start_key  = 1'b0;
        collision  = 1'b0;
        vga_vs2    = 1'b0;
        start_key2 = 1'b0;
        collision2 = 1'b0;
        @(negedge Clk);
        test_reset();
        test_start();
        test_collision_priority();
        test_gameover_hold();
        test_best_kept();
        test_promotion();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Produces the 3-bit `State` bus that the wall-motion, rotation and colour logic consumes: menu, three difficulty levels, game over.
- Counts survived frames, promotes the level at fixed frame thresholds, and ends the run on collision.
- Tracks current and best score in seconds, and pulses `game_reset` so wall and rotation logic restart cleanly.
- Sits between keyboard/collision logic and the game controller, clocked by the 50 MHz system clock.

Parameters:
- LEVEL2_FRAMES, 600: survived frames at which LEVEL1 promotes to LEVEL2.
- LEVEL3_FRAMES, 1800: survived frames at which LEVEL2 promotes to LEVEL3. Must be greater than LEVEL2_FRAMES.
- GAMEOVER_HOLD, 120: minimum frames in GAME_OVER before a start press is accepted.
- FRAMES_PER_SEC, 60: frames per score second.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- VGA_VS  in  1  VGA vertical sync (active-low pulse); the frame tick is its rising edge.
- start_key  in  1  start key level, high while held.
- collision  in  1  player/wall overlap level, valid any cycle.
- State  out  3  0=MENU, 1=LEVEL1, 2=LEVEL2, 3=LEVEL3, 4=GAME_OVER.
- game_reset  out  1  one-cycle pulse when a run starts.
- score_sec  out  10  seconds survived in the current/last run, saturates at 999.
- best_sec  out  10  best `score_sec` since reset.

Behaviour:
- **Reset** (`Reset_n` low, asynchronous): State=MENU; `game_reset`=0; `score_sec`, `best_sec`, frame counter, sub-second counter, hold counter and edge-detector flops all = 0.
- **Input conditioning:** `VGA_VS` and `start_key` each pass through a 2-FF synchronizer plus rising-edge detect. `frame_tick` and `start_edge` are 1-cycle pulses, 3 Clk after the input edge.
- **MENU:**
  - `start_edge` -> LEVEL1 next cycle.
  - `game_reset`=1 for that same single cycle.
  - Run counters and `score_sec` clear to 0.
- **LEVEL1/2/3, on each frame_tick:**
  - `run_frames` (16-bit) increments, saturating.
  - `sub` (0..FRAMES_PER_SEC-1) increments; on wrap `sub`=0 and `score_sec`+1, saturating at 999.
- **Promotion:**
  - LEVEL1 -> LEVEL2 on the cycle after `run_frames` becomes equal to LEVEL2_FRAMES.
  - LEVEL2 -> LEVEL3 the same way at LEVEL3_FRAMES.
  - LEVEL3 is terminal until collision.
- **Collision:** `collision`=1 in any level state -> GAME_OVER next cycle.
  - Collision wins over promotion and over `frame_tick` on the same cycle. That tick is not counted.
- **`start_edge` in level states:** ignored.
- **GAME_OVER entry:**
  - If `score_sec` > `best_sec`, `best_sec` <= `score_sec` one cycle after entry.
  - `score_sec` holds its final value.
  - The hold counter clears, then increments on each `frame_tick`, saturating at GAMEOVER_HOLD.
- **GAME_OVER exit:**
  - `start_edge` with hold counter >= GAMEOVER_HOLD -> LEVEL1, with a `game_reset` pulse and cleared run counters/`score_sec`.
  - Earlier presses are dropped, not queued.
- **Illegal State (5-7):** -> MENU next cycle; no `game_reset`.
- **Output timing:** all outputs are registered. `game_reset` is never high two consecutive cycles.

Decomposition:
- Package `game_pkg`:
  - `state_t` enum with fixed encodings MENU=3'd0, LEVEL1=3'd1, LEVEL2=3'd2, LEVEL3=3'd3, GAME_OVER=3'd4, shared with all State consumers.
  - `SCORE_MAX`=10'd999.
- Sub-module `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse. Clk and Reset_n as above; input `d`, output `rise`. Instantiated twice, once for `VGA_VS` and once for `start_key`.

Test Plan (sim params LEVEL2_FRAMES=4, LEVEL3_FRAMES=8, GAMEOVER_HOLD=3, FRAMES_PER_SEC=2):
- **Reset/start:** drive Reset_n low mid-run, release, press `start_key` -> `State`=0, all outputs 0. `start_key` rise -> exactly one `game_reset` cycle; State=1 four Clk after the key edge (3-cycle synchronizer/edge detect + 1-cycle state register).
- **Promotion:** from LEVEL1, 4 VS ticks -> State=2; 8 ticks -> State=3; after 8 ticks `score_sec`=4; 20 more ticks -> State stays 3.
- **Collision priority:** collision on the same cycle as the 4th `frame_tick` -> State=4, never 2; `score_sec`=1 (3 ticks counted), `best_sec`=1 next cycle.
- **Game-over hold:** press start after 2 ticks in GAME_OVER -> State stays 4, no `game_reset`. Press after 3 ticks -> State=1, `game_reset` pulse, `score_sec`=0, `best_sec` still 1.
- **Best score kept on worse run:** a run ending with `score_sec`=0 -> `best_sec` stays 1.
- **Saturation:** FRAMES_PER_SEC=1, 1005 ticks -> `score_sec`=999; force State=6 -> MENU next cycle, no `game_reset`.
